dht_reader: RTL and testbench

DHT_READER -- requirements
Module: dht_reader

---
 rtl/dht_pkg.sv | 31 +++
 rtl/dht_us_tick.sv | 35 +++
 rtl/dht_reader.sv | 167 ++++++++++++++++
 tb/tb_dht_reader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/dht_pkg.sv
// DHT temperature/humidity sensor reader: shared state encoding, frame width and default timing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dht_pkg;

    localparam int FRAME_W            = 40;
    localparam int DEF_CLK_HZ         = 50_000_000;
    localparam int DEF_START_LOW_US   = 18_000;
    localparam int DEF_POLL_MS        = 2_000;
    localparam int DEF_TIMEOUT_US     = 200;
    localparam int DEF_BIT1_THRESH_US = 50;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START_LOW,
        ST_REL_WAIT,
        ST_RESP_LOW,
        ST_RESP_HIGH,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_CHECK
    } dht_state_t;

    // Last byte of the frame is the 8-bit wrapping sum of the four data bytes.
    function automatic logic csum_ok(input logic [FRAME_W-1:0] f);
        logic [7:0] s;
        s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
        return (s == f[7:0]);
    endfunction

endpackage

// File: rtl/dht_us_tick.sv
// Microsecond prescaler: one-cycle tick every CLK_HZ/1e6 clocks.
// Latency: first tick DIV+1 cycles after reset release, then every DIV cycles.
// Backpressure: none, free running.
module dht_us_tick #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int DIV = CLK_HZ / 1_000_000;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_tick;

    // Count 0..DIV-1 and emit a registered pulse on wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == LAST) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/dht_reader.sv
// DHT single-wire reader: periodic start pulse, response handshake, 40-bit frame capture, checksum.
// Latency: result pulse one cycle after the falling edge ending bit 40 (plus 2-flop sync delay).
// Backpressure: none; results are one-cycle pulses, hym_data holds the last good frame.
module dht_reader
    import dht_pkg::*;
#(
    parameter int CLK_HZ         = DEF_CLK_HZ,
    parameter int START_LOW_US   = DEF_START_LOW_US,
    parameter int POLL_MS        = DEF_POLL_MS,
    parameter int TIMEOUT_US     = DEF_TIMEOUT_US,
    parameter int BIT1_THRESH_US = DEF_BIT1_THRESH_US
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               dht_in,
    output logic               dht_oe,
    output logic [FRAME_W-1:0] hym_data,
    output logic               data_valid,
    output logic               checksum_err,
    output logic               timeout_err,
    output logic               busy
);

    localparam logic [31:0] POLL_TICKS    = POLL_MS * 1000;
    localparam logic [31:0] START_TICKS   = START_LOW_US;
    localparam logic [31:0] TIMEOUT_TICKS = TIMEOUT_US;
    localparam logic [31:0] THRESH_TICKS  = BIT1_THRESH_US;
    localparam logic [5:0]  LAST_BIT      = 6'(FRAME_W - 1);

    logic [1:0]         r_sync;
    logic               r_line_d;
    logic               w_line;
    logic               w_fall;
    logic               w_tick;
    logic               w_sensor_phase;
    logic [31:0]        w_timer_nx;

    dht_state_t         r_state;
    logic [31:0]        r_timer;
    logic [5:0]         r_bit_cnt;
    logic [FRAME_W-1:0] r_shift;
    logic [FRAME_W-1:0] r_hym;
    logic               r_oe;
    logic               r_busy;
    logic               r_valid;
    logic               r_cs_err;
    logic               r_to_err;

    dht_us_tick #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    // Bring the asynchronous line into the clock domain; third flop gives edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync   <= 2'b00;
            r_line_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[0], dht_in};
            r_line_d <= r_sync[1];
        end
    end

    assign w_line = r_sync[1];
    // After release the synchronized line still shows our own start pulse for a few
    // cycles, so the sensor response is recognised by a genuine high-to-low edge.
    assign w_fall = r_line_d & ~w_line;

    // Including the tick of the deciding cycle makes the measured high time exact
    // in whole microseconds, so 50 vs 51 us resolve cleanly against the threshold.
    assign w_timer_nx = r_timer + {31'd0, w_tick};

    assign w_sensor_phase = (r_state == ST_REL_WAIT)  || (r_state == ST_RESP_LOW) ||
                            (r_state == ST_RESP_HIGH) || (r_state == ST_BIT_LOW)  ||
                            (r_state == ST_BIT_HIGH);

    // Transaction sequencer: phase timer, bit capture, checksum and result pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_hym     <= '0;
            r_oe      <= 1'b0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_cs_err  <= 1'b0;
            r_to_err  <= 1'b0;
        end else begin
            r_valid  <= 1'b0;
            r_cs_err <= 1'b0;
            r_to_err <= 1'b0;
            r_timer  <= w_timer_nx;
            if (w_sensor_phase && (r_timer >= TIMEOUT_TICKS)) begin
                r_to_err <= 1'b1;
                r_busy   <= 1'b0;
                r_state  <= ST_IDLE;
                r_timer  <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: if (r_timer >= POLL_TICKS) begin
                        r_state <= ST_START_LOW;
                        r_timer <= '0;
                        r_oe    <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                    ST_START_LOW: if (r_timer >= START_TICKS) begin
                        r_state <= ST_REL_WAIT;
                        r_timer <= '0;
                        r_oe    <= 1'b0;
                    end
                    ST_REL_WAIT: if (w_fall) begin
                        r_state <= ST_RESP_LOW;
                        r_timer <= '0;
                    end
                    ST_RESP_LOW: if (w_line) begin
                        r_state <= ST_RESP_HIGH;
                        r_timer <= '0;
                    end
                    ST_RESP_HIGH: if (!w_line) begin
                        r_state   <= ST_BIT_LOW;
                        r_timer   <= '0;
                        r_bit_cnt <= '0;
                    end
                    ST_BIT_LOW: if (w_line) begin
                        r_state <= ST_BIT_HIGH;
                        r_timer <= '0;
                    end
                    ST_BIT_HIGH: if (!w_line) begin
                        r_shift   <= {r_shift[FRAME_W-2:0], (w_timer_nx > THRESH_TICKS)};
                        r_bit_cnt <= r_bit_cnt + 6'd1;
                        r_timer   <= '0;
                        r_state   <= (r_bit_cnt == LAST_BIT) ? ST_CHECK : ST_BIT_LOW;
                    end
                    ST_CHECK: begin
                        if (csum_ok(r_shift)) begin
                            r_hym   <= r_shift;
                            r_valid <= 1'b1;
                        end else begin
                            r_cs_err <= 1'b1;
                        end
                        r_state <= ST_IDLE;
                        r_timer <= '0;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_timer <= '0;
                        r_oe    <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign dht_oe       = r_oe;
    assign hym_data     = r_hym;
    assign data_valid   = r_valid;
    assign checksum_err = r_cs_err;
    assign timeout_err  = r_to_err;
    assign busy         = r_busy;

endmodule

// File: tb/tb_dht_reader.sv
module tb_dht_reader;

    localparam int CLK_HZ       = 2_000_000;
    localparam int DIV          = CLK_HZ / 1_000_000;
    localparam int START_LOW_US = 100;
    localparam int POLL_MS      = 1;
    localparam int TIMEOUT_US   = 200;
    localparam int THRESH_US    = 50;
    localparam int POLL_CYC     = POLL_MS * 1000 * DIV;
    localparam int TO_CYC       = TIMEOUT_US * DIV;
    localparam int K_OK = 0, K_CS = 1, K_TO = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        r_sens = 1'b1;
    logic        dht_in, dht_oe, data_valid, checksum_err, timeout_err, busy;
    logic [39:0] hym_data;

    // Open-drain line: host pulls low, otherwise the sensor (or pull-up) sets the level.
    assign dht_in = dht_oe ? 1'b0 : r_sens;

    dht_reader #(
        .CLK_HZ(CLK_HZ), .START_LOW_US(START_LOW_US), .POLL_MS(POLL_MS),
        .TIMEOUT_US(TIMEOUT_US), .BIT1_THRESH_US(THRESH_US)
    ) dut (
        .clk(clk), .rst_n(rst_n), .dht_in(dht_in), .dht_oe(dht_oe),
        .hym_data(hym_data), .data_valid(data_valid), .checksum_err(checksum_err),
        .timeout_err(timeout_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int n_checks = 0, n_fail = 0;
    int n_dv = 0, n_ce = 0, n_to = 0, n_hym_glitch = 0;
    logic [39:0] hym_prev = '0;

    // Pulse counters and a watch that hym_data moves only together with data_valid.
    always @(negedge clk) begin
        if (rst_n) begin
            if (data_valid === 1'b1)   n_dv++;
            if (checksum_err === 1'b1) n_ce++;
            if (timeout_err === 1'b1)  n_to++;
            if (hym_data !== hym_prev && data_valid !== 1'b1) n_hym_glitch++;
        end
        hym_prev = hym_data;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_oe(input logic lvl, input int max_cyc, output bit ok, output int t);
        ok = 1'b0;
        t  = cyc;
        for (int k = 0; k < max_cyc; k++) begin
            @(negedge clk);
            if (dht_oe === lvl) begin
                ok = 1'b1;
                t  = cyc;
                break;
            end
        end
    endtask

    task automatic hold(input logic v, input int us);
        r_sens = v;
        repeat (us * DIV) @(negedge clk);
    endtask

    // Sensor: waits for the host release, answers 80/80 us, then nbits bits MSB first.
    task automatic sensor(input logic [39:0] f, input int lo, input int h0, input int h1,
                          input int nbits);
        bit ok;
        int t;
        wait_oe(1'b0, (START_LOW_US + 20) * DIV, ok, t);
        chk("release_seen", ok, 1);
        hold(1'b1, 20);
        hold(1'b0, 80);
        hold(1'b1, 80);
        for (int i = 0; i < nbits; i++) begin
            hold(1'b0, lo);
            hold(1'b1, f[39-i] ? h1 : h0);
        end
        if (nbits == 40) hold(1'b0, lo);
        r_sens = 1'b1;
    endtask

    // Reference: each bit is 1 exactly when its high time exceeds the threshold.
    function automatic logic [39:0] model_rx(input logic [39:0] f, input int h0, input int h1);
        logic [39:0] w;
        for (int i = 0; i < 40; i++) w[i] = ((f[i] ? h1 : h0) > THRESH_US);
        return w;
    endfunction

    function automatic bit model_sum_ok(input logic [39:0] w);
        int s;
        s = 0;
        for (int b = 1; b <= 4; b++) s += int'(w[b*8 +: 8]);
        return (s % 256) == int'(w[7:0]);
    endfunction

    typedef struct {
        logic [39:0] frame;
        int          lo_us;
        int          hi0;
        int          hi1;
        int          nbits;
        int          exp_kind;
        logic [39:0] exp_hym;
    } vec_t;

    vec_t vt[6];

    initial begin
        bit          ok;
        int          t, t0, t1, t_rel, dv0, ce0, to0, h0, h1;
        logic [39:0] f, w, prev;
        logic [7:0]  sb;

        vt[0] = '{40'h019000E677, 50, 27, 70, 40, K_OK, 40'h019000E677};
        vt[1] = '{40'h019000E678, 50, 27, 70, 40, K_CS, 40'h019000E677};
        vt[2] = '{40'hA53C0FF0E0, 30, 49, 51, 40, K_OK, 40'hA53C0FF0E0};
        vt[3] = '{40'h123456789A, 50, 27, 70, 20, K_TO, 40'hA53C0FF0E0};
        prev = 40'hA53C0FF0E0;
        for (int r = 4; r < 6; r++) begin
            f[39:8] = $urandom;
            sb = f[39:32] + f[31:24] + f[23:16] + f[15:8];
            f[7:0] = ($urandom_range(0, 1) == 1) ? sb : (sb ^ 8'h01);
            h0 = $urandom_range(15, 50);
            h1 = $urandom_range(51, 80);
            w = model_rx(f, h0, h1);
            vt[r].frame    = f;
            vt[r].lo_us    = $urandom_range(30, 60);
            vt[r].hi0      = h0;
            vt[r].hi1      = h1;
            vt[r].nbits    = 40;
            vt[r].exp_kind = model_sum_ok(w) ? K_OK : K_CS;
            vt[r].exp_hym  = model_sum_ok(w) ? w : prev;
            prev = vt[r].exp_hym;
        end

        repeat (4) @(negedge clk);
        chk("rst_oe", dht_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_hym", hym_data, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_cserr", checksum_err, 0);
        chk("rst_toerr", timeout_err, 0);
        rst_n = 1'b1;
        t_rel = cyc;

        for (int i = 0; i < 6; i++) begin
            wait_oe(1'b1, POLL_CYC + 200, ok, t);
            chk("start_seen", ok, 1);
            if (i == 0) chk_rng("first_start_latency", t - t_rel, POLL_CYC - 2, POLL_CYC + 4);
            chk("busy_in_txn", busy, 1);
            dv0 = n_dv; ce0 = n_ce; to0 = n_to;
            sensor(vt[i].frame, vt[i].lo_us, vt[i].hi0, vt[i].hi1, vt[i].nbits);
            for (int k = 0; k < (TIMEOUT_US + 50) * DIV && busy !== 1'b0; k++) @(negedge clk);
            chk("busy_end", busy, 0);
            repeat (2) @(negedge clk);
            chk("valid_cnt", n_dv - dv0, (vt[i].exp_kind == K_OK) ? 1 : 0);
            chk("cserr_cnt", n_ce - ce0, (vt[i].exp_kind == K_CS) ? 1 : 0);
            chk("toerr_cnt", n_to - to0, (vt[i].exp_kind == K_TO) ? 1 : 0);
            chk("hym_data", hym_data, vt[i].exp_hym);
        end

        // Silent sensor: timeout from release, then re-poll measured from the timeout.
        wait_oe(1'b1, POLL_CYC + 200, ok, t);
        chk("silent_start_seen", ok, 1);
        dv0 = n_dv; ce0 = n_ce; to0 = n_to;
        wait_oe(1'b0, (START_LOW_US + 20) * DIV, ok, t0);
        t1 = t0;
        ok = 1'b0;
        for (int k = 0; k < TO_CYC + 50; k++) begin
            @(negedge clk);
            if (timeout_err === 1'b1) begin
                ok = 1'b1;
                t1 = cyc;
                break;
            end
        end
        chk("silent_timeout_seen", ok, 1);
        chk_rng("timeout_latency", t1 - t0, TO_CYC - 2, TO_CYC + 3);
        chk("busy_after_timeout", busy, 0);
        wait_oe(1'b1, POLL_CYC + 200, ok, t);
        chk_rng("repoll_latency", t - t1, POLL_CYC - 2, POLL_CYC + 4);
        chk("silent_toerr_cnt", n_to - to0, 1);
        chk("silent_valid_cnt", n_dv - dv0, 0);
        chk("silent_cserr_cnt", n_ce - ce0, 0);

        // Reset in the middle of the start pulse.
        repeat (20) @(negedge clk);
        chk("oe_before_reset", dht_oe, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("reset_oe_same_cycle", dht_oe, 0);
        chk("reset_busy", busy, 0);
        chk("reset_hym", hym_data, 0);
        chk("reset_toerr", timeout_err, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        t_rel = cyc;
        wait_oe(1'b1, POLL_CYC + 200, ok, t);
        chk("post_reset_start_seen", ok, 1);
        chk_rng("post_reset_start_latency", t - t_rel, POLL_CYC - 2, POLL_CYC + 4);

        chk("hym_change_without_valid", n_hym_glitch, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
